// File: rtl/nn_sequencer.sv
// Host-facing sequencer for the 4-neuron perceptron datapath: streams parameter and input bytes,
// waits for the network to settle, captures outputs and hands them back one index at a time.
module nn_sequencer #(
  parameter int unsigned N_PARAM_BYTES = 24,
  parameter int unsigned N_INPUT_BYTES = 4,
  parameter int unsigned N_OUTPUTS     = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       load_params,
  input  logic       abort,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [1:0] selector,
  output logic [7:0] data_out,
  output logic [1:0] out_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StLoadParam = 3'd1;
  localparam logic [2:0] StLoadInput = 3'd2;
  localparam logic [2:0] StSettle    = 3'd3;
  localparam logic [2:0] StCapture   = 3'd4;
  localparam logic [2:0] StOutput    = 3'd5;

  localparam logic [1:0] SelHold    = 2'b00;
  localparam logic [1:0] SelParam   = 2'b01;
  localparam logic [1:0] SelInput   = 2'b10;
  localparam logic [1:0] SelCapture = 2'b11;

  // One shared counter serves byte loads and the settle delay; sized for the largest of them.
  localparam int unsigned MaxLoad  = (N_PARAM_BYTES > N_INPUT_BYTES) ? N_PARAM_BYTES
                                                                     : N_INPUT_BYTES;
  localparam int unsigned MaxCount = (MaxLoad > SETTLE_CYCLES) ? MaxLoad : SETTLE_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxCount) + 1;

  localparam logic [CntW-1:0] ParamLast  = CntW'(N_PARAM_BYTES - 1);
  localparam logic [CntW-1:0] InputLast  = CntW'(N_INPUT_BYTES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]      OutLast    = 2'(N_OUTPUTS - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      selector_q, selector_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      out_sel_q, out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept;

  assign s_ready = (state_q == StLoadParam) || (state_q == StLoadInput);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    selector_d  = SelHold;
    data_d      = data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = StIdle;
      cnt_d       = '0;
      out_sel_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_d = load_params ? StLoadParam : StLoadInput;
        end
        StLoadParam: begin
          if (accept) begin
            selector_d = SelParam;
            data_d     = s_data;
            if (cnt_q == ParamLast) begin
              cnt_d   = '0;
              state_d = StLoadInput;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StLoadInput: begin
          if (accept) begin
            selector_d = SelInput;
            data_d     = s_data;
            if (cnt_q == InputLast) begin
              cnt_d   = '0;
              state_d = StSettle;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_d   = '0;
            state_d = StCapture;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCapture: begin
          selector_d = SelCapture;
          out_sel_d  = '0;
          state_d    = StOutput;
        end
        StOutput: begin
          // First OUTPUT cycle only raises out_valid, so the host never sees pre-capture data.
          if (out_valid_q && out_ready) begin
            if (out_sel_q == OutLast) begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
              out_sel_d   = '0;
              done_d      = 1'b1;
            end else begin
              out_sel_d = out_sel_q + 1'b1;
            end
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      selector_q  <= SelHold;
      data_q      <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      selector_q  <= selector_d;
      data_q      <= data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign selector  = selector_q;
  assign data_out  = data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
